// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Registers operands, captures result/flags, returns them with a done pulse.
module alu_arbiter #(
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 4
) (
  input  logic                input_CLK,
  input  logic                input_Reset_n,
  input  logic                input_Valid0,
  input  logic [WIDTH-1:0]    input_A0,
  input  logic [WIDTH-1:0]    input_B0,
  input  logic [OP_WIDTH-1:0] input_ALUOp0,
  input  logic                input_Valid1,
  input  logic [WIDTH-1:0]    input_A1,
  input  logic [WIDTH-1:0]    input_B1,
  input  logic [OP_WIDTH-1:0] input_ALUOp1,
  output logic [WIDTH-1:0]    output_A,
  output logic [WIDTH-1:0]    output_B,
  output logic [OP_WIDTH-1:0] output_ALUOp,
  input  logic [WIDTH-1:0]    input_ALU,
  input  logic                input_Zero,
  input  logic                input_Negative,
  input  logic                input_Carry,
  output logic                output_Done0,
  output logic                output_Done1,
  output logic [WIDTH-1:0]    output_Result,
  output logic                output_Zero,
  output logic                output_Negative,
  output logic                output_Carry,
  output logic                output_Error,
  output logic                output_Busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic ptr_q;
  logic gnt_q;
  logic err_q;
  logic req_any;
  logic gnt_sel;
  logic op_legal;

  // Pick the winner: a lone requester, or the pointer's side on a tie.
  always_comb begin
    req_any  = input_Valid0 | input_Valid1;
    gnt_sel  = input_Valid1 & (~input_Valid0 | ptr_q);
    op_legal = (output_ALUOp <= OP_WIDTH'(9)) ||
               (output_ALUOp == OP_WIDTH'(12));
  end

  // State register.
  always_ff @(posedge input_CLK) begin
    if (!input_Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ISSUE -> DONE -> IDLE, one op every three cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on grant, result capture in ISSUE, pointer flip in DONE.
  always_ff @(posedge input_CLK) begin
    if (!input_Reset_n) begin
      ptr_q           <= 1'b0;
      gnt_q           <= 1'b0;
      err_q           <= 1'b0;
      output_A        <= '0;
      output_B        <= '0;
      output_ALUOp    <= '0;
      output_Result   <= '0;
      output_Zero     <= 1'b0;
      output_Negative <= 1'b0;
      output_Carry    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            gnt_q        <= gnt_sel;
            output_A     <= gnt_sel ? input_A1 : input_A0;
            output_B     <= gnt_sel ? input_B1 : input_B0;
            output_ALUOp <= gnt_sel ? input_ALUOp1 : input_ALUOp0;
          end
        end
        ISSUE: begin
          err_q           <= ~op_legal;
          output_Result   <= op_legal ? input_ALU : '0;
          output_Zero     <= op_legal & input_Zero;
          output_Negative <= op_legal & input_Negative;
          output_Carry    <= op_legal & input_Carry;
        end
        DONE: begin
          ptr_q <= ~gnt_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Done/Error are only ever visible in DONE, so they drop with the state.
  always_comb begin
    output_Busy  = (state_q != IDLE);
    output_Done0 = (state_q == DONE) & ~gnt_q;
    output_Done1 = (state_q == DONE) & gnt_q;
    output_Error = (state_q == DONE) & err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: ALU model, requester tasks,
// scoreboard monitor with a transaction-level arbitration model.
module tb_alu_arbiter;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        e;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [2];
  logic [15:0] a_in [2];
  logic [15:0] b_in [2];
  logic [3:0]  op_in [2];

  logic [15:0] o_a, o_b, res, alu_r;
  logic [3:0]  o_op;
  logic        alu_z, alu_n, alu_c;
  logic        d0, d1, oz, on, oc, oe, busy;

  int n_chk = 0;
  int n_fail = 0;

  resp_t q0[$];
  resp_t q1[$];
  int    grant_log[$];
  int    done_id[$];
  int    done_cyc[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16), .OP_WIDTH(4)) dut (
    .input_CLK(clk),
    .input_Reset_n(rst_n),
    .input_Valid0(vld[0]),
    .input_A0(a_in[0]),
    .input_B0(b_in[0]),
    .input_ALUOp0(op_in[0]),
    .input_Valid1(vld[1]),
    .input_A1(a_in[1]),
    .input_B1(b_in[1]),
    .input_ALUOp1(op_in[1]),
    .output_A(o_a),
    .output_B(o_b),
    .output_ALUOp(o_op),
    .input_ALU(alu_r),
    .input_Zero(alu_z),
    .input_Negative(alu_n),
    .input_Carry(alu_c),
    .output_Done0(d0),
    .output_Done1(d1),
    .output_Result(res),
    .output_Zero(oz),
    .output_Negative(on),
    .output_Carry(oc),
    .output_Error(oe),
    .output_Busy(busy)
  );

  function automatic resp_t ref_op(input logic [15:0] a, b,
                                   input logic [3:0] op);
    resp_t x;
    logic [16:0] t;
    x = '0;
    t = '0;
    if (!(op <= 4'd9 || op == 4'd12)) begin
      x.e = 1'b1;
      return x;
    end
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; x.r = t[15:0]; x.c = t[16]; end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; x.r = t[15:0]; x.c = t[16]; end
      4'd2: x.r = a & b;
      4'd3: x.r = a | b;
      4'd4: x.r = a ^ b;
      4'd5: x.r = a << b[3:0];
      4'd6: x.r = a >> b[3:0];
      4'd7: x.r = 16'($signed(a) >>> b[3:0]);
      4'd8: x.r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd9: x.r = ~a;
      default: x.r = b;
    endcase
    x.z = (x.r == 16'd0);
    x.n = x.r[15];
    return x;
  endfunction

  // External ALU; illegal opcodes produce junk that must never be forwarded.
  resp_t alu_t;
  always_comb begin
    alu_t = ref_op(o_a, o_b, o_op);
    alu_r = alu_t.e ? 16'hDEAD : alu_t.r;
    alu_z = alu_t.e | alu_t.z;
    alu_n = alu_t.e | alu_t.n;
    alu_c = alu_t.e | alu_t.c;
  end

  task automatic chk(input string nm, input logic [63:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: predicts grant/timing from sampled valids and pops the scoreboard.
  bit p_rstn = 1'b0;
  bit p_busy = 1'b0;
  bit p_v0 = 1'b0;
  bit p_v1 = 1'b0;
  bit p_iss = 1'b0;
  bit last = 1'b1;
  bit cur_w = 1'b0;
  int cyc = 0;

  initial begin
    bit exp_iss, is_iss, w;
    resp_t exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (!p_rstn) begin
        chk("reset_zero",
            {o_a, o_b, o_op, res, oz, on, oc, oe, d0, d1, busy}, 64'd0);
        last = 1'b1;
        p_iss = 1'b0;
        q0.delete();
        q1.delete();
      end else begin
        exp_iss = !p_busy && (p_v0 || p_v1);
        is_iss = busy && !d0 && !d1;
        chk("issue_timing", is_iss, exp_iss);
        chk("busy", busy, exp_iss || p_iss);
        if (p_iss) chk("done_id", {d1, d0}, cur_w ? 2 : 1);
        else chk("done_idle", {d1, d0}, 0);
        if (d0 || d1) begin
          if ((d1 ? q1.size() : q0.size()) == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            exp = d1 ? q1.pop_front() : q0.pop_front();
            chk("sb_resp", {res, oz, on, oc, oe}, exp);
          end
          done_id.push_back(d1 ? 1 : 0);
          done_cyc.push_back(cyc);
        end else begin
          chk("error_low", oe, 0);
        end
        if (exp_iss) begin
          w = (p_v0 && p_v1) ? !last : p_v1;
          chk("alu_a", o_a, a_in[w]);
          chk("alu_b", o_b, b_in[w]);
          chk("alu_op", o_op, op_in[w]);
          cur_w = w;
          last = w;
          grant_log.push_back(int'(w));
        end
        p_iss = exp_iss;
      end
      p_rstn = rst_n;
      p_busy = busy;
      p_v0 = vld[0];
      p_v1 = vld[1];
    end
  end

  task automatic issue(input int id, input logic [15:0] a, b,
                       input logic [3:0] op, input bit keep,
                       input int gap, output logic [19:0] obs);
    bit got;
    a_in[id] = a;
    b_in[id] = b;
    op_in[id] = op;
    if (id == 0) q0.push_back(ref_op(a, b, op));
    else q1.push_back(ref_op(a, b, op));
    vld[id] = 1'b1;
    got = 1'b0;
    obs = '0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk);
      #1;
      got = (id == 1) ? d1 : d0;
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      obs = {res, oz, on, oc, oe};
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      vld[id] = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int id, input int n);
    logic [19:0] ob;
    bit k;
    for (int i = 0; i < n; i++) begin
      k = (i < n - 1) && ($urandom_range(0, 1) == 1);
      issue(id, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
            k, $urandom_range(0, 2), ob);
    end
  endtask

  initial begin
    logic [19:0] o0, o1, o2;
    int n, nd;
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] o0, o1, o2;
    int n, nd;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      a_in[i] = '0;
      b_in[i] = '0;
      op_in[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 16'h0003, 16'h0004, 4'b0000, 1'b0, 1, o0);
    chk("t1_add", o0, 20'h00070);

    do_reset();
    fork
      issue(0, 16'h0005, 16'h0005, 4'b0001, 1'b0, 1, o0);
      issue(1, 16'h8000, 16'h0001, 4'b0011, 1'b0, 1, o1);
    join
    chk("t2_sub", o0, 20'h00008);
    chk("t2_or", o1, 20'h80014);
    n = done_cyc.size();
    chk("t2_order", {done_id[n-2], done_id[n-1]}, {32'd0, 32'd1});
    chk("t2_spacing", done_cyc[n-1] - done_cyc[n-2], 3);

    do_reset();
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++)
        issue(0, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 9)),
              i < 2, 0, o0);
      for (int j = 0; j < 3; j++)
        issue(1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 9)),
              j < 2, 0, o1);
    join
    chk("t3_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("t3_alternate", grant_log[i], i % 2);

    issue(1, 16'h1234, 16'h5678, 4'b1010, 1'b0, 1, o1);
    chk("t4_illegal", o1, 20'h00001);
    issue(1, 16'h0002, 16'h0003, 4'b0000, 1'b0, 1, o1);
    chk("t4_legal_after", o1, 20'h00050);

    nd = done_id.size();
    a_in[0] = 16'h0001;
    b_in[0] = 16'h0002;
    op_in[0] = 4'b0000;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_in_issue", {busy, d0, d1}, 3'b100);
    rst_n = 1'b0;
    vld[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_zero", {o_a, o_b, o_op, res, oz, on, oc, oe, d0, d1, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("t5_no_done", done_id.size(), nd);
    grant_log.delete();
    fork
      issue(0, 16'h0010, 16'h0001, 4'b0001, 1'b0, 1, o0);
      issue(1, 16'h0010, 16'h0002, 4'b0001, 1'b0, 1, o1);
    join
    chk("t5_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    issue(0, 16'h0001, 16'h0004, 4'b0101, 1'b1, 0, o0);
    issue(0, 16'h0001, 16'h0004, 4'b0101, 1'b0, 1, o2);
    chk("t6_first", o0, 20'h00100);
    chk("t6_second", o2, 20'h00100);
    n = done_cyc.size();
    chk("t6_spacing", done_cyc[n-1] - done_cyc[n-2], 3);

    fork
      rand_req(0, 40);
      rand_req(1, 40);
    join
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 16-bit ALU between two requesters: the main datapath control (req0) and the address/branch-offset unit (req1). It arbitrates round-robin, registers the winner's operands and opcode onto the ALU inputs, and captures the ALU result and flags. It returns them to the winner with a one-cycle done pulse. It sits between the control unit and the ALU; the ALU stays combinational and external.

Parameters:
WIDTH, 16, operand/result width
OP_WIDTH, 4, ALU opcode width

Ports:
input_CLK  input  1  system clock, all state on rising edge
input_Reset_n  input  1  synchronous active-low reset
input_Valid0  input  1  req0 request; held high with operands stable until output_Done0
input_A0, input_B0  input  WIDTH each  req0 operands
input_ALUOp0  input  OP_WIDTH  req0 opcode
input_Valid1, input_A1, input_B1, input_ALUOp1  input  1/WIDTH/WIDTH/OP_WIDTH  same, req1
output_A, output_B  output  WIDTH each  registered operands to ALU
output_ALUOp  output  OP_WIDTH  registered opcode to ALU
input_ALU  input  WIDTH  ALU result
input_Zero, input_Negative, input_Carry  input  1 each  ALU flags
output_Done0, output_Done1  output  1 each  one-cycle completion pulse per requester
output_Result  output  WIDTH  captured result, valid while a done is high
output_Zero, output_Negative, output_Carry  output  1 each  captured flags, valid with done
output_Error  output  1  high with done when opcode was illegal
output_Busy  output  1  high in ISSUE and DONE states

Behaviour:
- FSM states: IDLE, ISSUE, DONE. Reset state is IDLE.
- Reset (input_Reset_n low at an edge), including mid-operation:
  - state goes to IDLE and the priority pointer goes to 0 (req0 favoured).
  - All outputs go to 0: output_A/B/ALUOp, Result, flags, Error, Done0/1, Busy.
  - An in-flight operation is dropped with no done pulse. The requester re-requests after reset.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the requester named by the pointer.
  - On grant: latch that requester's A, B, ALUOp into output_A/B/ALUOp and store grant id; go to ISSUE.
- ISSUE:
  - The ALU sees the registered operands for the whole cycle.
  - At the end of the cycle, register input_ALU and the three flags into output_Result and flags.
  - Go to DONE.
- DONE:
  - Assert output_Done<id> for exactly one cycle; Result, flags and Error are stable.
  - Set pointer to the non-granted requester; go to IDLE.
- Latency: Valid seen in IDLE at edge N gives done high in cycle N+2. Back-to-back throughput is one operation per 3 cycles.
- Legal opcodes: 0000-1001 and 1100.
  - Illegal opcode (1010, 1011, 1101-1111): the FSM path and timing are unchanged.
  - output_Result=0, all flags=0, output_Error=1 during DONE. The ALU's undefined output is never forwarded.
- output_Error is 0 in every cycle where it is not asserted as above.
- Requester protocol:
  - Requester deasserts valid the cycle after its done. The IDLE cycle following DONE samples valid again; a still-high valid is a new request.
  - Operands must not change while valid is high and done has not arrived. Changes are ignored after the latch.
- output_A/B/ALUOp hold their last value outside ISSUE. Result and flags hold until the next capture.
- Flags are passed through untouched; the arbiter does no arithmetic.
- output_Done0 and output_Done1 are never high together.

Test Plan:
- Reset, then req0 only: Valid0=1, A0=0x0003, B0=0x0004, ALUOp0=0000 -> output_ALUOp=0000 during ISSUE; Done0 pulses 2 cycles later with Result=0x0007, Zero=0, Negative=0, Error=0; Done1 stays 0.
- Both valid from reset: req0 SUB 5-5, req1 OR 0x8000|0x0001.
  - req0 wins first: Done0 with Result=0x0000, Zero=1.
  - Then req1: Done1 with Result=0x8001, Negative=1.
  - Done pulses are 3 cycles apart.
- Fairness: hold both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1, and never two consecutive grants to one side.
- Illegal opcode: Valid1=1, ALUOp1=1010 -> Done1 with Result=0, Zero=Negative=Carry=0, Error=1; the next legal op has Error=0.
- Reset mid-operation: assert input_Reset_n=0 during ISSUE -> no Done pulse, all outputs 0, Busy=0; after release with both valid, req0 is granted first.
- Held valid: keep Valid0 high after Done0 with SLL A0=0x0001, B0=0x0004 -> second Done0 3 cycles after the first, Result=0x0010 both times.
